// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Purpose: decides when a branch in ID has to stall. A branch in ID gets its
// operands only from the register file and the WB forwarding path. If one of
// its sources is still being produced in EX, in MEM, or by a long-latency
// unit (divider/FPU), ID is stalled and a bubble is inserted into EX.
// Long-latency producers are tracked in a 64-entry pending-write scoreboard:
// entries 0..31 are the integer file and entries 32..63 are the float file.
// A small FSM classifies each stall. A watchdog raises a sticky error flag
// when a stall lasts MAX_STALL cycles.
//
// Optional feature (macro BRANCH_HAZARD_PERF_EN): when the macro is defined,
// two saturating cycle counters are added, one for pipe stalls and one for
// long-latency stalls.
//
// Ports:
//   clk, rst_n                   core clock; synchronous active-low reset
//   id_valid, id_branch          ID holds a valid branch/compare
//   float_read[1:0]              [1] rs1 is float, [0] rs2 is float
//   rs1id, rs2id                 ID source registers
//   wbex, fw_ie, rdex            EX producer: writes back, float file, rd
//   wbmem, fw_imem, rdmem        MEM producer: writes back, float file, rd
//   lo_issue, lo_rd, lo_float    long-latency op issued (sets scoreboard bit)
//   lo_wb, lo_wb_rd, lo_wb_float long-latency writeback (clears scoreboard bit)
//   id_flush                     ID instruction is killed
//   stall_id, bubble_ex          hold PC/IF/ID; insert NOP into EX
//   stall_err                    sticky watchdog error
//   stall_cause                  00 none, 01 pipe, 10 long-latency
//   perf_pipe_cyc, perf_long_cyc present only with BRANCH_HAZARD_PERF_EN
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic [1:0]       float_read,
  input  logic [4:0]       rs1id,
  input  logic [4:0]       rs2id,
  input  logic             wbex,
  input  logic             fw_ie,
  input  logic [4:0]       rdex,
  input  logic             wbmem,
  input  logic             fw_imem,
  input  logic [4:0]       rdmem,
  input  logic             lo_issue,
  input  logic [4:0]       lo_rd,
  input  logic             lo_float,
  input  logic             lo_wb,
  input  logic [4:0]       lo_wb_rd,
  input  logic             lo_wb_float,
  input  logic             id_flush,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             stall_err,
  output logic [1:0]       stall_cause
`ifdef BRANCH_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_pipe_cyc,
  output logic [CNT_W-1:0] perf_long_cyc
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ST_PIPE = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  localparam int SC_W = $clog2(MAX_STALL + 1);

  logic [1:0]      state_q, state_d;
  logic [63:0]     sb_q, sb_d;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            stall_err_q, stall_err_d;

  logic            br_active;
  logic [1:0]      hit_pipe;
  logic [1:0]      hit_long;
  logic            hz_pipe, hz_long;

  // Per-source matching. Integer x0 never matches anything, but float f0 is
  // a real register and does match.
  logic [4:0] src_idx [2];
  logic       src_flt [2];
  assign src_idx[0] = rs1id;
  assign src_idx[1] = rs2id;
  assign src_flt[0] = float_read[1];
  assign src_flt[1] = float_read[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic is_x0;
      assign is_x0 = !src_flt[gi] && (src_idx[gi] == 5'd0);
      assign hit_pipe[gi] = !is_x0 &&
        ((wbex  && (rdex  == src_idx[gi]) && (fw_ie   == src_flt[gi])) ||
         (wbmem && (rdmem == src_idx[gi]) && (fw_imem == src_flt[gi])));
      assign hit_long[gi] = !is_x0 && sb_q[{src_flt[gi], src_idx[gi]}];
    end
  endgenerate

  assign br_active = id_valid && id_branch && !id_flush;
  assign hz_pipe   = br_active && (|hit_pipe);
  assign hz_long   = br_active && (|hit_long);

  assign stall_id    = hz_pipe || hz_long;
  assign bubble_ex   = stall_id;
  assign stall_cause = hz_long ? 2'b10 : (hz_pipe ? 2'b01 : 2'b00);
  assign stall_err   = stall_err_q;

  always_comb begin
    sb_d = sb_q;
    // Clear first so that a same-cycle set of the same bit wins.
    if (lo_wb)
      sb_d[{lo_wb_float, lo_wb_rd}] = 1'b0;
    if (lo_issue && !(!lo_float && (lo_rd == 5'd0)))
      sb_d[{lo_float, lo_rd}] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (id_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz_long)      state_d = ST_LONG;
          else if (hz_pipe) state_d = ST_PIPE;
        end
        ST_PIPE: begin
          if (hz_long)       state_d = ST_LONG;
          else if (!hz_pipe) state_d = IDLE;
        end
        ST_LONG: begin
          if (!hz_long && !hz_pipe) state_d = IDLE;
          else if (!hz_long)        state_d = ST_PIPE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Watchdog: counts consecutive stall cycles, saturates, and latches the
  // error once the count reaches MAX_STALL. The stall itself is not broken.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!stall_id)
      stall_cnt_d = '0;
    else if (stall_cnt_q != SC_W'(MAX_STALL))
      stall_cnt_d = stall_cnt_q + 1'b1;
    stall_err_d = stall_err_q || (stall_cnt_d == SC_W'(MAX_STALL));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sb_q        <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

`ifdef BRANCH_HAZARD_PERF_EN
  logic [CNT_W-1:0] pipe_cyc_q, pipe_cyc_d;
  logic [CNT_W-1:0] long_cyc_q, long_cyc_d;

  always_comb begin
    pipe_cyc_d = pipe_cyc_q;
    long_cyc_d = long_cyc_q;
    if ((stall_cause == 2'b01) && (pipe_cyc_q != '1))
      pipe_cyc_d = pipe_cyc_q + 1'b1;
    if ((stall_cause == 2'b10) && (long_cyc_q != '1))
      long_cyc_d = long_cyc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_cyc_q <= '0;
      long_cyc_q <= '0;
    end else begin
      pipe_cyc_q <= pipe_cyc_d;
      long_cyc_q <= long_cyc_d;
    end
  end

  assign perf_pipe_cyc = pipe_cyc_q;
  assign perf_long_cyc = long_cyc_q;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_ctrl
//
// Directed test bench for branch_hazard_ctrl. It drives hand-written vectors
// and compares the outputs (and the FSM state) against hand-computed values.
// The DUT is built with MAX_STALL=4 so that the watchdog can be reached
// quickly.
// ---------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PIPE = 2'd1;
  localparam logic [1:0] S_LONG = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_branch, id_flush;
  logic [1:0] float_read;
  logic [4:0] rs1id, rs2id;
  logic       wbex, fw_ie, wbmem, fw_imem;
  logic [4:0] rdex, rdmem;
  logic       lo_issue, lo_float, lo_wb, lo_wb_float;
  logic [4:0] lo_rd, lo_wb_rd;
  logic       stall_id, bubble_ex, stall_err;
  logic [1:0] stall_cause;
`ifdef BRANCH_HAZARD_PERF_EN
  logic [15:0] perf_pipe_cyc, perf_long_cyc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.MAX_STALL(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_branch(id_branch), .float_read(float_read),
    .rs1id(rs1id), .rs2id(rs2id),
    .wbex(wbex), .fw_ie(fw_ie), .rdex(rdex),
    .wbmem(wbmem), .fw_imem(fw_imem), .rdmem(rdmem),
    .lo_issue(lo_issue), .lo_rd(lo_rd), .lo_float(lo_float),
    .lo_wb(lo_wb), .lo_wb_rd(lo_wb_rd), .lo_wb_float(lo_wb_float),
    .id_flush(id_flush),
    .stall_id(stall_id), .bubble_ex(bubble_ex),
    .stall_err(stall_err), .stall_cause(stall_cause)
`ifdef BRANCH_HAZARD_PERF_EN
    , .perf_pipe_cyc(perf_pipe_cyc), .perf_long_cyc(perf_long_cyc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_branch = 0; id_flush = 0; float_read = 2'b00;
    rs1id = 5'd31; rs2id = 5'd31;
    wbex = 0; fw_ie = 0; rdex = 0; wbmem = 0; fw_imem = 0; rdmem = 0;
    lo_issue = 0; lo_rd = 0; lo_float = 0;
    lo_wb = 0; lo_wb_rd = 0; lo_wb_float = 0;
  endtask

  task automatic branch(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] fr);
    id_valid = 1; id_branch = 1; rs1id = r1; rs2id = r2; float_read = fr;
  endtask

  task automatic check_out(input string tag, input logic st, input logic [1:0] cause);
    check({tag, ".stall_id"},  {31'd0, stall_id},  {31'd0, st});
    check({tag, ".bubble_ex"}, {31'd0, bubble_ex}, {31'd0, st});
    check({tag, ".cause"},     {30'd0, stall_cause}, {30'd0, cause});
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    #1;
    check_out("reset", 1'b0, 2'b00);
    check("reset.err",   {31'd0, stall_err},   32'd0);
    check("reset.state", {30'd0, dut.state_q}, {30'd0, S_IDLE});

    // EX load-use: producer in EX, then MEM, then gone.
    idle(); branch(5'd5, 5'd31, 2'b00); wbex = 1; rdex = 5'd5;
    #1; check_out("lu.c0", 1'b1, 2'b01);
    check("lu.c0.state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    step(); wbex = 0; wbmem = 1; rdmem = 5'd5;
    #1; check_out("lu.c1", 1'b1, 2'b01);
    check("lu.c1.state", {30'd0, dut.state_q}, {30'd0, S_PIPE});
    step(); wbmem = 0;
    #1; check_out("lu.c2", 1'b0, 2'b00);
    check("lu.c2.state", {30'd0, dut.state_q}, {30'd0, S_PIPE});
    step();
    #1; check("lu.c3.state", {30'd0, dut.state_q}, {30'd0, S_IDLE});

    // x0 never matches, f0 does.
    idle(); branch(5'd0, 5'd31, 2'b00); wbex = 1; rdex = 5'd0; fw_ie = 0;
    #1; check_out("x0", 1'b0, 2'b00);
    fw_ie = 1; float_read = 2'b10;
    #1; check_out("f0", 1'b1, 2'b01);
    step(); idle(); step();

    // File mismatch: EX writes f7, branch reads x7.
    idle(); branch(5'd7, 5'd31, 2'b00); wbex = 1; rdex = 5'd7; fw_ie = 1;
    #1; check_out("filemis", 1'b0, 2'b00);
    step();

    // Long-latency issue to x0 must not set a scoreboard bit.
    idle(); lo_issue = 1; lo_rd = 5'd0; lo_float = 0;
    step(); lo_issue = 0; branch(5'd0, 5'd31, 2'b00);
    #1; check_out("lo_x0", 1'b0, 2'b00);
    step();

    // Long-latency on f3, watchdog fires after 4 stall cycles.
    idle(); lo_issue = 1; lo_rd = 5'd3; lo_float = 1; branch(5'd31, 5'd3, 2'b01);
    #1; check_out("long.issue", 1'b0, 2'b00);
    step(); lo_issue = 0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      check_out($sformatf("long.c%0d", i), 1'b1, 2'b10);
      check($sformatf("long.c%0d.err", i), {31'd0, stall_err}, (i >= 5) ? 32'd1 : 32'd0);
      if (i >= 2)
        check($sformatf("long.c%0d.state", i), {30'd0, dut.state_q}, {30'd0, S_LONG});
      step();
    end
    lo_wb = 1; lo_wb_rd = 5'd3; lo_wb_float = 1;
    #1; check_out("long.wb", 1'b1, 2'b10);
    step(); lo_wb = 0;
    #1; check_out("long.done", 1'b0, 2'b00);
    check("long.done.err", {31'd0, stall_err}, 32'd1);
    step();

    // Same-cycle set and clear of x9: set wins.
    idle(); lo_issue = 1; lo_rd = 5'd9; lo_float = 0;
    lo_wb = 1; lo_wb_rd = 5'd9; lo_wb_float = 0;
    step(); lo_issue = 0; lo_wb = 0; branch(5'd9, 5'd31, 2'b00);
    #1; check_out("setclr", 1'b1, 2'b10);
    lo_wb = 1; lo_wb_rd = 5'd9; lo_wb_float = 0;
    step(); lo_wb = 0;
    #1; check_out("clr9", 1'b0, 2'b00);
    step();

    // Flush during ST_LONG: no stall that cycle, IDLE next, bit kept.
    idle(); lo_issue = 1; lo_rd = 5'd3; lo_float = 1;
    step(); lo_issue = 0; branch(5'd31, 5'd3, 2'b01);
    #1; check_out("fl.pre", 1'b1, 2'b10);
    step();
    #1; check("fl.state_long", {30'd0, dut.state_q}, {30'd0, S_LONG});
    id_flush = 1;
    #1; check_out("fl.flush", 1'b0, 2'b00);
    step(); id_flush = 0;
    #1; check("fl.state_idle", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    check_out("fl.bitkept", 1'b1, 2'b10);

    // Reset mid-stall: error cleared, scoreboard empty.
    rst_n = 0;
    step(); rst_n = 1;
    #1; check("rst.err", {31'd0, stall_err}, 32'd0);
    check_out("rst.sb", 1'b0, 2'b00);
    check("rst.state", {30'd0, dut.state_q}, {30'd0, S_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
